// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter. Sends one command byte to the device
// over the open-drain PS/2 clock/data pair and reports ACK (tx_done) or
// NACK/timeout (tx_err). rx_inhibit holds off the companion receiver while busy.
//
// Ports:
//   clk_sys      system clock
//   rst          synchronous active-high reset
//   tx_req       one-cycle send request, accepted only while idle
//   tx_byte      byte to send, sampled on the accepting cycle
//   tx_busy      transfer in progress (every state except idle)
//   tx_done      one-cycle pulse: device acknowledged the byte
//   tx_err       one-cycle pulse: NACK or timeout
//   rx_inhibit   mirror of tx_busy
//   ps2_clk_in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
module ps2_tx #(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       tx_req,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    if (CLK_FREQ_HZ == 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_tx: CLK_FREQ_HZ must be nonzero, INHIBIT/TIMEOUT_CYCLES at least 2");
    end

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES);
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

    // The INHIBIT state covers all but the last low-clock cycle; START supplies
    // that final cycle with the start bit already on the data line.
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 2);
    localparam logic [TmrW-1:0] TmoLast = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [TmrW-1:0] TmoMax  = TmrW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StSend,
        StWaitAck,
        StWaitRel,
        StDone,
        StErr
    } state_e;

    // Input synchronizers; reset to the idle-high bus level so no false fall.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fall;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    state_e          state_q;
    logic [8:0]      shift_q;      // {parity, data}, shifted out LSB first
    logic [3:0]      bit_cnt_q;
    logic [InhW-1:0] inh_cnt_q;
    logic [TmrW-1:0] timer_q;
    logic            busy_q, done_q, err_q, clk_oe_q, data_oe_q;
    logic            timed;
    logic            timeout_hit;

    assign timed       = (state_q == StSend) || (state_q == StWaitAck) || (state_q == StWaitRel);
    // Fires on the edge where the elapsed count reaches TIMEOUT_CYCLES.
    assign timeout_hit = (timer_q >= TmoLast);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else if (timed && timeout_hit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= StErr;
        end else begin
            if (timed && (timer_q != TmoMax)) begin
                timer_q <= timer_q + TmrW'(1);
            end
            case (state_q)
                StIdle: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (tx_req) begin
                        shift_q   <= {~^tx_byte, tx_byte};
                        inh_cnt_q <= '0;
                        clk_oe_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (inh_cnt_q == InhLast) begin
                        data_oe_q <= 1'b1;
                        state_q   <= StStart;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + InhW'(1);
                    end
                end
                StStart: begin
                    clk_oe_q  <= 1'b0;
                    timer_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= StSend;
                end
                StSend: begin
                    if (fall) begin
                        if (bit_cnt_q == 4'd9) begin
                            data_oe_q <= 1'b0;
                            state_q   <= StWaitAck;
                        end else begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[8:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                StWaitAck: begin
                    if (fall) begin
                        if (data_s2_q) begin
                            err_q   <= 1'b1;
                            state_q <= StErr;
                        end else begin
                            state_q <= StWaitRel;
                        end
                    end
                end
                StWaitRel: begin
                    if (clk_s2_q && data_s2_q) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StErr: begin
                    err_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    busy_q    <= 1'b0;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign tx_busy     = busy_q;
    assign rx_inhibit  = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx with a simple PS/2 device model on an
// open-drain bus. Frame samples are stored as {stop, parity, d7..d0, start}.
module tb_ps2_tx;

    localparam int unsigned Inh  = 50;
    localparam int unsigned Tmo  = 2000;
    localparam int          Half = 20;

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic       tx_busy, tx_done, tx_err, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(
        .CLK_FREQ_HZ   (50_000_000),
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .tx_req     (tx_req),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .rx_inhibit (rx_inhibit),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #10 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk_sys) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_req(input logic [7:0] b);
        @(negedge clk_sys);
        tx_req  = 1'b1;
        tx_byte = b;
        @(negedge clk_sys);
        tx_req  = 1'b0;
        tx_byte = 8'h00;
    endtask

    // Device model: waits for the request-to-send, samples the start bit, then
    // gives npulses clock pulses sampling data on each rising edge. A full
    // frame (10 pulses) is followed by an ack bit driven low when ack_low.
    task automatic dev_frame(input int npulses, input logic ack_low,
                             output logic [10:0] smp, output bit ok);
        int n;
        ok  = 1'b1;
        smp = '0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 1000) ok = 1'b0;
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 1000) ok = 1'b0;
        if (!ok) return;
        cycles(Half);
        smp[0] = data_line;
        for (int i = 1; i <= npulses; i++) begin
            dev_clk_low = 1'b1;
            cycles(Half);
            dev_clk_low = 1'b0;
            smp[i] = data_line;
            cycles(Half);
        end
        if (npulses == 10) begin
            dev_data_low = ack_low;
            cycles(Half);
            dev_clk_low = 1'b1;
            cycles(Half);
            dev_clk_low = 1'b0;
            cycles(Half);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tx_busy !== 1'b0 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: tx_busy=%b after %0d cycles, required 0", name, tx_busy, n);
        end
        cycles(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        checks++;
        if ({tx_busy, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {tx_busy, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe});
        end
        rst = 1'b0;
        cycles(5);
        checks++;
        if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 000",
                     {tx_busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_send(input logic [7:0] b, input logic [10:0] exp, input string name);
        logic [10:0] smp;
        bit          ok;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(b);
        checks++;
        if ({tx_busy, rx_inhibit, ps2_clk_oe} !== 3'b111) begin
            errors++;
            $display("FAIL %s_accept: busy/inhibit/clk_oe=%b required 111", name,
                     {tx_busy, rx_inhibit, ps2_clk_oe});
        end
        dev_frame(10, 1'b1, smp, ok);
        wait_idle(name);
        checks++;
        if (!ok || smp !== exp) begin
            errors++;
            $display("FAIL %s_frame: got %b (ok=%0d) required %b", name, smp, ok, exp);
        end
        checks++;
        if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
            errors++;
            $display("FAIL %s_pulses: done=%0d err=%0d required done=1 err=0", name,
                     done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL %s_release: oe=%b required 00", name, {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_nack();
        logic [10:0] smp;
        bit          ok;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'hF4);
        dev_frame(10, 1'b0, smp, ok);
        wait_idle("nack");
        checks++;
        if (!ok || smp !== 11'h5E8) begin
            errors++;
            $display("FAIL nack_frame: got %b (ok=%0d) required %b", smp, ok, 11'h5E8);
        end
        checks++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
            errors++;
            $display("FAIL nack_pulses: err=%0d done=%0d required err=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL nack_release: oe=%b required 00", {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_timeout();
        int   n, m, d0, e0;
        logic last_d;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'h3C);
        n = 0;
        last_d = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < Inh + 100) begin
            last_d = ps2_data_oe;
            n++;
            @(negedge clk_sys);
        end
        checks++;
        if (n !== Inh) begin
            errors++;
            $display("FAIL inhibit_len: clock held %0d cycles, required %0d", n, Inh);
        end
        checks++;
        if (last_d !== 1'b1) begin
            errors++;
            $display("FAIL start_bit: data_oe=%b in last low-clock cycle, required 1", last_d);
        end
        m = 0;
        while (tx_err !== 1'b1 && m < Tmo + 100) begin
            @(negedge clk_sys);
            m++;
        end
        checks++;
        if (m !== Tmo) begin
            errors++;
            $display("FAIL timeout_len: tx_err after %0d cycles, required %0d", m, Tmo);
        end
        wait_idle("timeout");
        checks++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0 ||
            {ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulses: err=%0d done=%0d oe=%b required err=1 done=0 oe=00",
                     err_cnt - e0, done_cnt - d0, {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_ignore_second_req();
        logic [10:0] smp;
        bit          ok;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'hF4);
        fork
            dev_frame(10, 1'b1, smp, ok);
            begin
                cycles(150);
                tx_req  = 1'b1;
                tx_byte = 8'hAA;
                cycles(1);
                tx_req  = 1'b0;
                tx_byte = 8'h00;
            end
        join
        wait_idle("ignore");
        checks++;
        if (!ok || smp !== 11'h5E8) begin
            errors++;
            $display("FAIL ignore_frame: got %b (ok=%0d) required %b", smp, ok, 11'h5E8);
        end
        checks++;
        if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
            errors++;
            $display("FAIL ignore_pulses: done=%0d err=%0d required done=1 err=0",
                     done_cnt - d0, err_cnt - e0);
        end
        cycles(20);
        checks++;
        if ({tx_busy, ps2_clk_oe} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_no_queue: busy/clk_oe=%b required 00", {tx_busy, ps2_clk_oe});
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] smp;
        bit          ok;
        int          d0, e0;
        send_req(8'hF4);
        dev_frame(4, 1'b1, smp, ok);
        checks++;
        if (!ok || smp[4:0] !== 5'b01000) begin
            errors++;
            $display("FAIL partial_frame: got %b (ok=%0d) required 01000", smp[4:0], ok);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        cycles(1);
        checks++;
        if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: busy/clk_oe/data_oe=%b required 000",
                     {tx_busy, ps2_clk_oe, ps2_data_oe});
        end
        rst = 1'b0;
        cycles(5);
        checks++;
        if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin
            errors++;
            $display("FAIL mid_reset_pulses: done=%0d err=%0d required 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        test_send(8'h5A, 11'h6B4, "after_reset");
    endtask

    initial begin
        rst          = 1'b1;
        tx_req       = 1'b0;
        tx_byte      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        test_reset();
        test_send(8'hF4, 11'h5E8, "send_f4");
        test_send(8'hFF, 11'h7FE, "parity_ff");
        test_nack();
        test_timeout();
        test_ignore_second_req();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
